// File: rtl/inside_pkg.sv
// rtl/inside_pkg.sv - shared types and width helpers for the inside scheduler
//
// Purpose: FSM state encoding plus width helpers derived from the anchor
//          width N, the query widths XW/YW and the slot count K.
// Ports:   none (package).

package inside_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Query-minus-anchor differences need one extra bit over the query width.
    function automatic int dx_w(input int xw);
        return xw + 1;
    endfunction

    function automatic int dy_w(input int yw);
        return yw + 1;
    endfunction

    // Radius is N+1 bits signed; its square fits in 2N+2 bits.
    function automatic int r2_w(input int n);
        return 2 * n + 2;
    endfunction

    // Sum of two squares, sized from the wider (x) difference so it never overflows.
    function automatic int h_w(input int xw);
        return 2 * (xw + 1) + 1;
    endfunction

    function automatic int idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/inside_eval.sv
// rtl/inside_eval.sv - two-stage pipelined point-in-circle evaluator
//
// Purpose: stage 1 registers dx, dy and r^2; stage 2 registers
//          (dx^2 + dy^2 <= r^2) gated by the slot-valid tag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid_i          an anchor is issued this cycle
//   in_slot_ok_i        the issued slot holds a written anchor
//   in_idx_i            slot index carried as a tag
//   xd_i, yd_i          query point (signed)
//   xa_i, ya_i, ra_i    anchor centre and radius (signed)
//   s1_valid_o          stage 1 holds an entry
//   out_valid_o         stage 2 result valid
//   out_idx_o           slot index of the stage 2 result
//   out_inside_o        point inside (or on) circle and slot valid

module inside_eval
    import inside_pkg::*;
#(
    parameter int N  = 8,
    parameter int XW = 4 * N + 10,
    parameter int YW = 3 * N + 7,
    parameter int IW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    input  logic                 in_slot_ok_i,
    input  logic [IW-1:0]        in_idx_i,
    input  logic signed [XW-1:0] xd_i,
    input  logic signed [YW-1:0] yd_i,
    input  logic signed [N-1:0]  xa_i,
    input  logic signed [N-1:0]  ya_i,
    input  logic signed [N:0]    ra_i,
    output logic                 s1_valid_o,
    output logic                 out_valid_o,
    output logic [IW-1:0]        out_idx_o,
    output logic                 out_inside_o
);

    localparam int DXW = dx_w(XW);
    localparam int DYW = dy_w(YW);
    localparam int R2W = r2_w(N);
    localparam int HW  = h_w(XW);
    localparam int RW  = N + 1;

    logic signed [DXW-1:0]   dx_d, dx_q;
    logic signed [DYW-1:0]   dy_d, dy_q;
    logic signed [R2W-1:0]   ra_ext, r2_s;
    logic [R2W-1:0]          r2_d, r2_q;
    logic                    s1_valid_q, s1_ok_q;
    logic [IW-1:0]           s1_idx_q;

    logic signed [2*DXW-1:0] dx_ext, dx_sq;
    logic signed [2*DYW-1:0] dy_ext, dy_sq;
    logic [HW-1:0]           h_sum;
    logic                    in_circle;

    logic                    out_valid_q, out_inside_q;
    logic [IW-1:0]           out_idx_q;

    // Stage 1: sign-extend both operands explicitly before subtracting.
    always_comb begin
        dx_d   = {xd_i[XW-1], xd_i} - {{(DXW-N){xa_i[N-1]}}, xa_i};
        dy_d   = {yd_i[YW-1], yd_i} - {{(DYW-N){ya_i[N-1]}}, ya_i};
        ra_ext = {{(R2W-RW){ra_i[RW-1]}}, ra_i};
        r2_s   = ra_ext * ra_ext;
        r2_d   = r2_s;
    end

    // Stage 2: squares are non-negative, so the sum and compare are unsigned.
    always_comb begin
        dx_ext    = {{DXW{dx_q[DXW-1]}}, dx_q};
        dy_ext    = {{DYW{dy_q[DYW-1]}}, dy_q};
        dx_sq     = dx_ext * dx_ext;
        dy_sq     = dy_ext * dy_ext;
        h_sum     = {1'b0, dx_sq} + {{(HW-2*DYW){1'b0}}, dy_sq};
        in_circle = (h_sum <= {{(HW-R2W){1'b0}}, r2_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q         <= '0;
            dy_q         <= '0;
            r2_q         <= '0;
            s1_valid_q   <= 1'b0;
            s1_ok_q      <= 1'b0;
            s1_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_inside_q <= 1'b0;
            out_idx_q    <= '0;
        end else begin
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            r2_q         <= r2_d;
            s1_valid_q   <= in_valid_i;
            s1_ok_q      <= in_slot_ok_i;
            s1_idx_q     <= in_idx_i;
            out_valid_q  <= s1_valid_q;
            out_inside_q <= in_circle & s1_ok_q;
            out_idx_q    <= s1_idx_q;
        end
    end

    assign s1_valid_o   = s1_valid_q;
    assign out_valid_o  = out_valid_q;
    assign out_idx_o    = out_idx_q;
    assign out_inside_o = out_inside_q;

endmodule

// File: rtl/inside_sched.sv
// rtl/inside_sched.sv - anchor table, sequencing FSM and result accumulator
//
// Purpose: runs one query point against K anchor slots through a shared
//          inside_eval pipeline and reports mask, count, all and any.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cfg_we/idx/xa/ya/ra           anchor table write (idle only)
//   cfg_busy                      writes are dropped while high
//   q_valid/q_ready/q_xd/q_yd     query handshake and point
//   res_valid/res_ready           result handshake
//   res_mask/count/all/any        result fields

module inside_sched
    import inside_pkg::*;
#(
    parameter int N  = 8,
    parameter int K  = 4,
    parameter int XW = 4 * N + 10,
    parameter int YW = 3 * N + 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [idx_w(K)-1:0]      cfg_idx,
    input  logic signed [N-1:0]      cfg_xa,
    input  logic signed [N-1:0]      cfg_ya,
    input  logic signed [N:0]        cfg_ra,
    output logic                     cfg_busy,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic signed [XW-1:0]     q_xd,
    input  logic signed [YW-1:0]     q_yd,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [K-1:0]             res_mask,
    output logic [cnt_w(K)-1:0]      res_count,
    output logic                     res_all,
    output logic                     res_any
);

    localparam int IW = idx_w(K);
    localparam int CW = cnt_w(K);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [XW-1:0]  xd_q;
    logic signed [YW-1:0]  yd_q;

    logic [K-1:0]          slot_vld_q;
    logic signed [N-1:0]   xa_q [K];
    logic signed [N-1:0]   ya_q [K];
    logic signed [N:0]     ra_q [K];

    logic [K-1:0]          mask_d, mask_q;
    logic [CW-1:0]         count_d, count_q;
    logic                  all_d, all_q, any_d, any_q;

    logic                  accept, cfg_wr;
    logic                  ev_s1_valid, ev_valid, ev_inside;
    logic [IW-1:0]         ev_idx;

    assign accept = q_valid && (state_q == IDLE);
    assign cfg_wr = cfg_we && (state_q == IDLE) && (int'(cfg_idx) < K);

    // Anchor table: a write in the accept cycle lands before RUN reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= '0;
            for (int i = 0; i < K; i++) begin
                xa_q[i] <= '0;
                ya_q[i] <= '0;
                ra_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            slot_vld_q[cfg_idx] <= 1'b1;
            xa_q[cfg_idx]       <= cfg_xa;
            ya_q[cfg_idx]       <= cfg_ya;
            ra_q[cfg_idx]       <= cfg_ra;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (idx_q == IW'(K - 1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            // Once stage 1 is empty, the last result retires on this edge.
            DRAIN: begin
                if (!ev_s1_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        all_d   = all_q;
        any_d   = any_q;
        if (accept) begin
            mask_d  = '0;
            count_d = '0;
            all_d   = 1'b0;
            any_d   = 1'b0;
        end else if (ev_valid) begin
            mask_d[ev_idx] = ev_inside;
            count_d        = count_q + CW'(ev_inside);
        end
        if ((state_q == DRAIN) && (state_d == DONE)) begin
            any_d = |mask_d;
            all_d = (|slot_vld_q) && ((mask_d & slot_vld_q) == slot_vld_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xd_q    <= '0;
            yd_q    <= '0;
            mask_q  <= '0;
            count_q <= '0;
            all_q   <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                xd_q <= q_xd;
                yd_q <= q_yd;
            end
            mask_q  <= mask_d;
            count_q <= count_d;
            all_q   <= all_d;
            any_q   <= any_d;
        end
    end

    inside_eval #(
        .N  (N),
        .XW (XW),
        .YW (YW),
        .IW (IW)
    ) u_eval (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (state_q == RUN),
        .in_slot_ok_i (slot_vld_q[idx_q]),
        .in_idx_i     (idx_q),
        .xd_i         (xd_q),
        .yd_i         (yd_q),
        .xa_i         (xa_q[idx_q]),
        .ya_i         (ya_q[idx_q]),
        .ra_i         (ra_q[idx_q]),
        .s1_valid_o   (ev_s1_valid),
        .out_valid_o  (ev_valid),
        .out_idx_o    (ev_idx),
        .out_inside_o (ev_inside)
    );

    assign cfg_busy  = (state_q != IDLE);
    assign q_ready   = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_mask  = mask_q;
    assign res_count = count_q;
    assign res_all   = all_q;
    assign res_any   = any_q;

endmodule

// File: tb/tb_inside_sched.sv
// tb/tb_inside_sched.sv - directed self-checking bench for inside_sched

module tb_inside_sched;

    localparam int N  = 8;
    localparam int K  = 4;
    localparam int XW = 4 * N + 10;
    localparam int YW = 3 * N + 7;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_idx = '0;
    logic signed [N-1:0]  cfg_xa = '0;
    logic signed [N-1:0]  cfg_ya = '0;
    logic signed [N:0]    cfg_ra = '0;
    logic                 cfg_busy;
    logic                 q_valid = 1'b0;
    logic                 q_ready;
    logic signed [XW-1:0] q_xd = '0;
    logic signed [YW-1:0] q_yd = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [K-1:0]         res_mask;
    logic [2:0]           res_count;
    logic                 res_all;
    logic                 res_any;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inside_sched #(.N(N), .K(K), .XW(XW), .YW(YW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_xa    (cfg_xa),
        .cfg_ya    (cfg_ya),
        .cfg_ra    (cfg_ra),
        .cfg_busy  (cfg_busy),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_xd      (q_xd),
        .q_yd      (q_yd),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mask  (res_mask),
        .res_count (res_count),
        .res_all   (res_all),
        .res_any   (res_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_cfg(input int idx, input int x, input int y, input int r);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_xa  = 8'(x);
        cfg_ya  = 8'(y);
        cfg_ra  = 9'(r);
    endtask

    task automatic set_slot(input int idx, input int x, input int y, input int r);
        @(negedge clk);
        drive_cfg(idx, x, y, r);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Presents the query for one edge; returns at the negedge after acceptance.
    task automatic q_start(input string tag, input int x, input int y);
        chk({tag, ".q_ready"}, q_ready, 1);
        q_valid = 1'b1;
        q_xd    = XW'(x);
        q_yd    = YW'(y);
        @(negedge clk);
        q_valid = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic q_finish(input string tag, input int cyc0, input logic [3:0] em,
                            input int ec, input logic ea, input logic el);
        int cyc;
        cyc = cyc0;
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 6);
        chk({tag, ".mask"}, res_mask, em);
        chk({tag, ".count"}, res_count, ec);
        chk({tag, ".any"}, res_any, ea);
        chk({tag, ".all"}, res_all, el);
        chk({tag, ".q_ready_busy"}, q_ready, 0);
    endtask

    task automatic ack(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, ".valid_clr"}, res_valid, 0);
        chk({tag, ".q_ready_back"}, q_ready, 1);
    endtask

    task automatic query(input string tag, input int x, input int y, input logic [3:0] em,
                         input int ec, input logic ea, input logic el);
        @(negedge clk);
        q_start(tag, x, y);
        q_finish(tag, 0, em, ec, ea, el);
        ack(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.q_ready", q_ready, 1);
        chk("rst.busy", cfg_busy, 0);
        chk("rst.valid", res_valid, 0);
        chk("rst.mask", res_mask, 0);
        chk("rst.count", res_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.q_ready", q_ready, 1);

        set_slot(0, 0, 0, 5);
        set_slot(1, 10, 10, 3);
        set_slot(2, 3, 0, 4);
        query("t1", 3, 4, 4'b0101, 2, 1'b1, 1'b0);

        set_slot(3, -20, -20, 1);
        query("t2", 3, 4, 4'b0101, 2, 1'b1, 1'b0);

        set_slot(1, 3, 4, 0);
        query("t3", 3, 4, 4'b0111, 3, 1'b1, 1'b0);

        set_slot(0, -128, -128, 255);
        query("t4", 127, 127, 4'b0000, 0, 1'b0, 1'b0);

        // Back-pressure: hold DONE and attempt table writes meanwhile.
        @(negedge clk);
        q_start("t5", 52, 52);
        q_finish("t5", 0, 4'b0001, 1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_cfg(0, 100, 100, 1);
            @(negedge clk);
            chk("t5.hold_valid", res_valid, 1);
            chk("t5.hold_mask", res_mask, 4'b0001);
            chk("t5.hold_q_ready", q_ready, 0);
        end
        cfg_we = 1'b0;
        ack("t5");
        query("t6", 52, 52, 4'b0001, 1, 1'b1, 1'b0);

        // Write in the accept edge is used; a write during RUN is dropped.
        @(negedge clk);
        drive_cfg(2, 52, 52, 0);
        q_start("t7", 52, 52);
        chk("t7.busy", cfg_busy, 1);
        drive_cfg(1, 52, 52, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        q_finish("t7", 1, 4'b0101, 2, 1'b1, 1'b0);
        ack("t7");
        query("t8", 52, 52, 4'b0101, 2, 1'b1, 1'b0);

        set_slot(1, 52, 52, 1);
        set_slot(3, 52, 53, -1);
        query("t9", 52, 52, 4'b1111, 4, 1'b1, 1'b1);

        // Reset three edges into RUN, after slot 0 has retired into the mask.
        @(negedge clk);
        q_start("t10", 52, 52);
        repeat (3) @(posedge clk);
        #2;
        chk("t10.partial_mask", res_mask, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t10.rst_mask", res_mask, 0);
        chk("t10.rst_count", res_count, 0);
        chk("t10.rst_busy", cfg_busy, 0);
        chk("t10.rst_valid", res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        query("t11", 52, 52, 4'b0000, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inside_sched.md
Name: inside_sched

Overview:
- Sequences one shared, pipelined point-in-circle evaluator across a table of K anchors for a single query point (xD, yD).
- Produces a per-anchor inside mask, a count, and all/any flags for the trilateration decision stage.
- Sits between the position-estimate front end (query source) and the decision logic (result sink).
- The anchor table is written through a simple config port while the block is idle.

Parameters:
N, 8, anchor coordinate width (signed); anchor radius width is N+1 (signed).
K, 4, number of anchor slots (K >= 1).
XW, 4*N+10, query x width (signed).
YW, 3*N+7, query y width (signed).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_we  in  1  anchor-table write strobe.
cfg_idx  in  clog2(K)  slot index; values >= K are ignored.
cfg_xa  in  N  anchor x (signed).
cfg_ya  in  N  anchor y (signed).
cfg_ra  in  N+1  anchor radius (signed).
cfg_busy  out  1  high when state != IDLE; writes are dropped while high.
q_valid  in  1  query valid.
q_ready  out  1  high only in IDLE.
q_xd  in  XW  query x (signed).
q_yd  in  YW  query y (signed).
res_valid  out  1  result valid; held until accepted.
res_ready  in  1  sink accepts result.
res_mask  out  K  bit i = 1 iff slot i is valid and (xD-xA)^2+(yD-yA)^2 <= rA^2.
res_count  out  clog2(K+1)  popcount of res_mask.
res_all  out  1  res_mask covers every valid slot and at least one slot is valid.
res_any  out  1  |res_mask.

Behaviour:
- Reset (async assert): state=IDLE, slot valid bits=0, table data=0, pipeline valids=0, res_*=0, q_ready=1 after reset releases.
- Config: cfg_we=1 with cfg_busy=0 writes the slot and sets its valid bit at that edge.
- Config while busy: the write is silently dropped.
- Config in the same edge as a query accept: the write commits first, so the new value is used by that query.
- FSM IDLE: on q_valid&&q_ready (edge 0), latch q_xd/q_yd, idx=0, go to RUN.
- FSM RUN: issue slot idx each cycle, idx++. After issuing idx=K-1 (edge K), go to DRAIN.
- FSM DRAIN: wait until the pipeline is empty (2 cycles), then go to DONE.
- FSM DONE: res_valid=1 and res_* stable. On res_valid&&res_ready, clear res_valid and go to IDLE. The next query can be accepted no earlier than the following cycle.
- Latency: res_valid is high in the cycle after edge K+2 (K=4: visible after edge 6). Latency is fixed and independent of slot validity. Invalid slots are still issued, but their result bit is forced to 0.
- Evaluator stage 1 (registered):
  - dx = xD - sext(xA), XW+1 bits.
  - dy = yD - sext(yA), YW+1 bits.
  - r2 = rA*rA, 2N+2 bits.
  - Tag: idx and slot-valid bit.
- Evaluator stage 2 (registered):
  - H = dx*dx + dy*dy, 2*(XW+1)+1 bits, never overflows.
  - inside = (H <= zext(r2)), unsigned compare, since both operands are >= 0.
  - Writes res_mask[tag] = inside & valid.
- At query accept, res_mask and res_count clear; the count accumulates as bits are written.
- Boundary distance == radius counts as inside. Negative radius is squared like any other value.
- Back-pressure: DONE holds indefinitely while res_ready=0; q_ready stays 0 throughout.
- Reset mid-query aborts immediately, with no partial result. The table is also cleared and must be reloaded.

Decomposition:
- Package inside_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - width helpers for dx/dy/H/r2 as functions of N, XW, YW;
  - clog2-based index and count widths.
- Sub-module inside_eval: the 2-stage pipelined evaluator with tag pass-through (valid, idx in; inside, idx out).
- The anchor table, FSM and accumulator live in inside_sched.

Test Plan:
- N=8, K=4. Slots:
  - 0 = (0,0,5)
  - 1 = (10,10,3)
  - 2 = (3,0,4)
  - 3 = empty

  Query (3,4). Expected res_mask=0101, res_count=2, res_any=1, res_all=0. res_valid rises after edge 6. Slot 0 exercises the dist=radius boundary.
- Same query with slot 3 = (-20,-20,1): mask unchanged (0101), so invalid→valid-but-outside also gives 0. Then set slot 1 = (3,4,0): mask=0111.
- Signed extremes: slot 0 = (-128,-128,255), query (127,127). dx=dy=255, H=130050 > 65025, so mask bit 0 = 0. Checks sign extension and width.
- Hold res_ready=0 for 10 cycles in DONE: res_* stable, q_ready=0, and cfg writes dropped (table readback via a later query is unchanged). Then the handshake returns the FSM to IDLE.
- cfg_we and q_valid in the same edge in IDLE: the new slot value is used by that query. A write issued during RUN is ignored.
- Deassert rst_n at cycle 3 of RUN: outputs go to 0 asynchronously and the valid bits clear. After release, a query gives mask=0000, res_any=0, res_all=0.
